// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit.
// Holds the opcode constants, the FSM state enumeration and the encodings
// of the alu_op, alu_src_b and pc_src control fields, plus small helpers
// used by the control FSM.
package multicycle_control_pkg;

  // instruction[31:26] values recognised by the control unit
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // alu_op
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_src
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IMMEX  = 4'd8,
    S_IMMWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  // States that drive a memory access and may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts consecutive stalled cycles of one memory access.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clear the count (asserted on every state change)
//   busy        : a memory state is waiting (mem_ready low) this cycle
//   expired     : this stalled cycle is the TIMEOUT-th in a row
// TIMEOUT = 0 disables expiry. The count saturates and never wraps.
module mem_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Number of stalled cycles already spent in the current memory state.
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (busy && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current stalled cycle is number cnt+1; expire when it hits TIMEOUT.
  always_comb begin
    expired = 1'b0;
    if ((TIMEOUT > 0) && busy && ((int'(cnt) + 1) >= TIMEOUT)) begin
      expired = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle MIPS subset
// (LW, SW, R-type, ADDI, ORI, BEQ, BNE, J).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   opcode       : instruction[31:26], looked at only in DECODE
//   mem_ready    : memory access completes this cycle
//   pc_write .. err : datapath controls, instr_done/illegal_op pulses,
//                  sticky err after a memory timeout
//   dbg_state    : current FSM state (reads S_FETCH while reset is high)
// Handshake: a memory state (FETCH, MEMRD, MEMWR) presents its request and
// holds it; the access completes in the first cycle mem_ready is sampled
// high, and the FSM moves on at that clock edge. With MEM_HANDSHAKE = 0
// mem_ready is treated as constantly high. mem_ready high in the cycle the
// timer expires still counts as completion.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       err,
  output state_t     dbg_state
);

  state_t     state;
  state_t     next_state;
  logic [5:0] op_q;      // opcode captured in DECODE for the later states
  logic       ready;
  logic       expired;

  assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Clearing on every state change means each memory state starts at zero.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (next_state != state),
    .busy    (is_mem_state(state) && !ready),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (ready)        next_state = S_DECODE;
        else if (expired) next_state = S_ERROR;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_RTYPE:        next_state = S_EXEC;
          OP_ADDI, OP_ORI: next_state = S_IMMEX;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          default:         next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (ready)        next_state = S_MEMWB;
        else if (expired) next_state = S_ERROR;
      end
      S_MEMWR: begin
        if (ready)        next_state = S_FETCH;
        else if (expired) next_state = S_ERROR;
      end
      S_EXEC:   next_state = S_ALUWB;
      S_IMMEX:  next_state = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_FETCH;
    endcase
  end

  // Outputs depend on state (and ready in memory states); reset forces all 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_src        = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    err           = 1'b0;
    dbg_state     = S_FETCH;
    if (!reset) begin
      dbg_state = state;
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          ir_write  = ready;
          pc_write  = ready;
        end
        S_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          alu_op     = ALU_ADD;
          illegal_op = !is_legal(opcode);
          instr_done = !is_legal(opcode);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = ready;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_IMMEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        end
        S_IMMWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PCSRC_ALUOUT;
          branch_ne     = (op_q == OP_BNE);
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        S_ERROR: err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Three instances share clk, opcode and
// mem_ready: default parameters, TIMEOUT = 4, and MEM_HANDSHAKE = 0. Each
// instruction is expanded by a reference model into per-cycle expected
// outputs and states, which a driver plays back and checks.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal_op;
    logic       err;
  } o_t;

  localparam int OW = $bits(o_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m = 1'b1;
  logic       rst_t = 1'b1;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  wire o_t obs_m, obs_t, obs_n;
  state_t st_m, st_t, st_n;

  multicycle_control dut_m (
    .clk(clk), .reset(rst_m), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obs_m.pc_write), .pc_write_cond(obs_m.pc_write_cond),
    .branch_ne(obs_m.branch_ne), .i_or_d(obs_m.i_or_d),
    .mem_read(obs_m.mem_read), .mem_write(obs_m.mem_write),
    .ir_write(obs_m.ir_write), .reg_dst(obs_m.reg_dst),
    .mem_to_reg(obs_m.mem_to_reg), .reg_write(obs_m.reg_write),
    .alu_src_a(obs_m.alu_src_a), .alu_src_b(obs_m.alu_src_b),
    .alu_op(obs_m.alu_op), .pc_src(obs_m.pc_src),
    .instr_done(obs_m.instr_done), .illegal_op(obs_m.illegal_op),
    .err(obs_m.err), .dbg_state(st_m)
  );

  multicycle_control #(.TIMEOUT(4)) dut_t (
    .clk(clk), .reset(rst_t), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obs_t.pc_write), .pc_write_cond(obs_t.pc_write_cond),
    .branch_ne(obs_t.branch_ne), .i_or_d(obs_t.i_or_d),
    .mem_read(obs_t.mem_read), .mem_write(obs_t.mem_write),
    .ir_write(obs_t.ir_write), .reg_dst(obs_t.reg_dst),
    .mem_to_reg(obs_t.mem_to_reg), .reg_write(obs_t.reg_write),
    .alu_src_a(obs_t.alu_src_a), .alu_src_b(obs_t.alu_src_b),
    .alu_op(obs_t.alu_op), .pc_src(obs_t.pc_src),
    .instr_done(obs_t.instr_done), .illegal_op(obs_t.illegal_op),
    .err(obs_t.err), .dbg_state(st_t)
  );

  multicycle_control #(.MEM_HANDSHAKE(0)) dut_n (
    .clk(clk), .reset(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(obs_n.pc_write), .pc_write_cond(obs_n.pc_write_cond),
    .branch_ne(obs_n.branch_ne), .i_or_d(obs_n.i_or_d),
    .mem_read(obs_n.mem_read), .mem_write(obs_n.mem_write),
    .ir_write(obs_n.ir_write), .reg_dst(obs_n.reg_dst),
    .mem_to_reg(obs_n.mem_to_reg), .reg_write(obs_n.reg_write),
    .alu_src_a(obs_n.alu_src_a), .alu_src_b(obs_n.alu_src_b),
    .alu_op(obs_n.alu_op), .pc_src(obs_n.pc_src),
    .instr_done(obs_n.instr_done), .illegal_op(obs_n.illegal_op),
    .err(obs_n.err), .dbg_state(st_n)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  state_t        st_q[$];
  logic          rdy_q[$];
  logic [5:0]    op_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int step          = 0;

  logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                                6'b001101, 6'b000100, 6'b000101, 6'b000010};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic o_t obs_of(input int which);
    if (which == 0) return obs_m;
    if (which == 1) return obs_t;
    return obs_n;
  endfunction

  function automatic state_t st_of(input int which);
    if (which == 0) return st_m;
    if (which == 1) return st_t;
    return st_n;
  endfunction

  function automatic bit tb_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  task automatic push(input o_t o, input logic r, input state_t s,
                      input logic [5:0] op);
    exp_q.push_back(o);
    st_q.push_back(s);
    rdy_q.push_back(r);
    op_q.push_back(op);
  endtask

  function automatic logic rnd_rdy(input bit nh);
    return nh ? 1'b0 : logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction. sf/sm are the
  // stalled cycles before fetch/data access completes; nh models an
  // instance whose memory always completes at once while mem_ready stays 0.
  task automatic gen_instr(input logic [5:0] op, input int sf, input int sm,
                           input bit nh);
    o_t o;
    for (int i = 0; i < sf; i++) begin
      o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
      push(o, 1'b0, S_FETCH, junk());
    end
    o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
    o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, !nh, S_FETCH, junk());

    o = '0; o.alu_src_b = 2'b11;
    if (!tb_legal(op)) begin
      o.illegal_op = 1'b1; o.instr_done = 1'b1;
      push(o, rnd_rdy(nh), S_DECODE, op);
      return;
    end
    push(o, rnd_rdy(nh), S_DECODE, op);

    if (op == 6'b100011 || op == 6'b101011) begin
      o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      push(o, rnd_rdy(nh), S_MEMADR, junk());
      for (int i = 0; i <= sm; i++) begin
        o = '0; o.i_or_d = 1'b1;
        if (op == 6'b100011) o.mem_read = 1'b1;
        else begin
          o.mem_write = 1'b1;
          o.instr_done = (i == sm);
        end
        push(o, (i == sm) && !nh, (op == 6'b100011) ? S_MEMRD : S_MEMWR,
             junk());
      end
      if (op == 6'b100011) begin
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.instr_done = 1'b1;
        push(o, rnd_rdy(nh), S_MEMWB, junk());
      end
    end else if (op == 6'b000000) begin
      o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
      push(o, rnd_rdy(nh), S_EXEC, junk());
      o = '0; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
      push(o, rnd_rdy(nh), S_ALUWB, junk());
    end else if (op == 6'b001000 || op == 6'b001101) begin
      o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
      o.alu_op = (op == 6'b001101) ? 2'b11 : 2'b00;
      push(o, rnd_rdy(nh), S_IMMEX, junk());
      o = '0; o.reg_write = 1'b1; o.instr_done = 1'b1;
      push(o, rnd_rdy(nh), S_IMMWB, junk());
    end else if (op == 6'b000100 || op == 6'b000101) begin
      o = '0; o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
      o.pc_src = 2'b01; o.branch_ne = (op == 6'b000101); o.instr_done = 1'b1;
      push(o, rnd_rdy(nh), S_BRANCH, junk());
    end else begin
      o = '0; o.pc_write = 1'b1; o.pc_src = 2'b10; o.instr_done = 1'b1;
      push(o, rnd_rdy(nh), S_JUMP, junk());
    end
  endtask

  // ---------------- driver ----------------
  // Plays n queued cycles (all if n < 0) on one instance, releasing its reset.
  task automatic play(input int which, input int n);
    int cnt;
    o_t e;
    state_t s;
    cnt = (n < 0) ? exp_q.size() : n;
    for (int i = 0; i < cnt; i++) begin
      @(posedge clk); #1;
      if (which == 0) rst_m = 1'b0;
      else if (which == 1) rst_t = 1'b0;
      else rst_n = 1'b0;
      mem_ready = rdy_q.pop_front();
      opcode    = op_q.pop_front();
      e         = exp_q.pop_front();
      s         = st_q.pop_front();
      @(negedge clk);
      check($sformatf("dut%0d.step%0d.out", which, step),
            32'(obs_of(which)), 32'(e));
      check($sformatf("dut%0d.step%0d.state", which, step),
            32'(st_of(which)), 32'(s));
      step++;
    end
  endtask

  task automatic flush();
    exp_q.delete(); st_q.delete(); rdy_q.delete(); op_q.delete();
  endtask

  task automatic check_reset(input int which, input string tag);
    check({tag, ".out"}, 32'(obs_of(which)), 32'd0);
    check({tag, ".state"}, 32'(st_of(which)), 32'(S_FETCH));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [5:0] op;
    o_t o;

    // all instances held in reset: every output 0
    mem_ready = 1'b1;
    @(negedge clk);
    check_reset(0, "reset_m");
    check_reset(1, "reset_t");
    check_reset(2, "reset_n");

    // directed: R-type, LW with 3 stalls, BNE, illegal 111111
    gen_instr(6'b000000, 0, 0, 0); play(0, -1);
    gen_instr(6'b100011, 0, 3, 0); play(0, -1);
    gen_instr(6'b000101, 0, 0, 0); play(0, -1);
    gen_instr(6'b111111, 0, 0, 0); play(0, -1);

    // randomized instruction stream with random stalls
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 8) == 8) begin
        op = junk();
        while (tb_legal(op)) op = junk();
      end else begin
        op = legal_ops[$urandom_range(0, 7)];
      end
      gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      play(0, -1);
    end

    // reset while stalled in MEMWR, then a clean LW
    gen_instr(6'b101011, 0, 3, 0);
    play(0, 5);
    flush();
    @(posedge clk); #1;
    rst_m = 1'b1; mem_ready = 1'b0; opcode = junk();
    @(negedge clk);
    check_reset(0, "reset_in_memwr");
    gen_instr(6'b100011, 0, 0, 0); play(0, -1);

    // TIMEOUT = 4: fetch starves, ERROR after 4 cycles, err held
    for (int i = 0; i < 4; i++) begin
      o = '0; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
      push(o, 1'b0, S_FETCH, junk());
    end
    for (int i = 0; i < 4; i++) begin
      o = '0; o.err = 1'b1;
      push(o, logic'($urandom_range(0, 1)), S_ERROR, junk());
    end
    play(1, -1);
    @(posedge clk); #1;
    rst_t = 1'b1;
    @(negedge clk);
    check_reset(1, "timeout_reset");
    gen_instr(6'b000010, 0, 0, 0); play(1, -1);

    // MEM_HANDSHAKE = 0 with mem_ready stuck low
    gen_instr(6'b100011, 0, 0, 1); play(2, -1);
    gen_instr(6'b101011, 0, 0, 1); play(2, -1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
